// File: rtl/pi_access_pkg.sv
// Shared types and widths for the Pi RAM access block.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pi_access_pkg;

  localparam int PI_ADDR_W = 17;
  localparam int PI_DATA_W = 8;

  // Request handshake walk: wait for request, wait for bus slot, drive RAM, report done.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_SLOT = 2'd1,
    ST_ACCESS    = 2'd2,
    ST_DONE      = 2'd3
  } pi_access_state_t;

  // Request fields latched from the SPI side while the request level is high.
  typedef struct packed {
    logic                 rw_b;
    logic [PI_ADDR_W-1:0] addr;
    logic [PI_DATA_W-1:0] data;
  } pi_req_t;

endpackage

// File: rtl/pi_access_sync2.sv
// Two-flop synchronizer for level signals crossing into the clk domain.
// Latency: two clk edges from input change to output change.
// Backpressure: none; levels only, pulses shorter than a clk period may be lost.
module sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // First flop may go metastable; second flop gives it a full cycle to settle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pi_access.sv
// Arbitrates one Pi request into a granted RAM bus slot and returns a done level.
// Latency: pi_done_out rises ACCESS_CYCLES+1 edges after the edge that samples pi_slot.
// Backpressure: requester holds pi_pending_in until done; a started access always completes.
module pi_access
  import pi_access_pkg::*;
#(
  parameter int ACCESS_CYCLES = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pi_pending_in,
  input  logic [PI_ADDR_W-1:0] pi_addr,
  input  logic [PI_DATA_W-1:0] pi_data_in,
  input  logic                 pi_rw_b,
  input  logic                 pi_slot,
  output logic                 pi_done_out,
  output logic [PI_DATA_W-1:0] pi_rd_data,
  output logic [PI_ADDR_W-1:0] ram_addr,
  output logic [PI_DATA_W-1:0] ram_data_out,
  output logic                 ram_data_oe,
  input  logic [PI_DATA_W-1:0] ram_data_in,
  output logic                 ram_we_n,
  output logic                 ram_oe_n
);

  localparam int CNT_W = $clog2(ACCESS_CYCLES + 1);
  // Index of the final access cycle, where the access ends and read data is sampled.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ACCESS_CYCLES - 1);
  // Last cycle with the write strobe low; the final cycle holds data with we_n high.
  localparam logic [CNT_W-1:0] WE_LAST  = CNT_W'(ACCESS_CYCLES - 2);

  logic pend_s;

  pi_access_state_t     state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  pi_req_t              req_q, req_d;
  logic                 done_q, done_d;
  logic                 we_n_q, we_n_d;
  logic                 oe_n_q, oe_n_d;
  logic                 data_oe_q, data_oe_d;
  logic [PI_ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [PI_DATA_W-1:0] ram_wdat_q, ram_wdat_d;
  logic [PI_DATA_W-1:0] rd_data_q, rd_data_d;
  logic                 in_access_d;

  // The request level arrives from the SPI clock domain.
  sync2 #(
    .WIDTH (1)
  ) u_pend_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (pi_pending_in),
    .q_o   (pend_s)
  );

  // Next-state logic: request capture, slot wait, fixed-length access, done hold.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    case (state_q)
      ST_IDLE: begin
        if (pend_s) begin
          req_d.rw_b = pi_rw_b;
          req_d.addr = pi_addr;
          req_d.data = pi_data_in;
          state_d    = ST_WAIT_SLOT;
        end
      end
      ST_WAIT_SLOT: begin
        // A withdrawn request wins over a coincident slot so no strobe is issued.
        if (!pend_s) begin
          state_d = ST_IDLE;
        end else if (pi_slot) begin
          state_d = ST_ACCESS;
          cnt_d   = '0;
        end
      end
      ST_ACCESS: begin
        // Runs to completion regardless of pend_s; pend_s only picks the exit.
        if (cnt_q == LAST_CNT) begin
          cnt_d   = '0;
          state_d = pend_s ? ST_DONE : ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        if (!pend_s) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // RAM strobes and bus values are registered from the next state so they line up
  // with the ACCESS state cycle by cycle and cannot glitch.
  always_comb begin
    in_access_d = (state_d == ST_ACCESS);
    we_n_d      = !(in_access_d && !req_q.rw_b && (cnt_d <= WE_LAST));
    oe_n_d      = !(in_access_d && req_q.rw_b);
    data_oe_d   = in_access_d && !req_q.rw_b;
    ram_addr_d  = in_access_d ? req_q.addr : ram_addr_q;
    ram_wdat_d  = in_access_d ? req_q.data : ram_wdat_q;
    rd_data_d   = rd_data_q;
    if ((state_q == ST_ACCESS) && (cnt_q == LAST_CNT) && req_q.rw_b) begin
      rd_data_d = ram_data_in;
    end
    // Done asserts one edge after entering DONE and drops on the edge that leaves it.
    done_d = (state_q == ST_DONE) && pend_s;
  end

  // State, request and output registers; reset releases every RAM strobe at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      req_q      <= '0;
      done_q     <= 1'b0;
      we_n_q     <= 1'b1;
      oe_n_q     <= 1'b1;
      data_oe_q  <= 1'b0;
      ram_addr_q <= '0;
      ram_wdat_q <= '0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      done_q     <= done_d;
      we_n_q     <= we_n_d;
      oe_n_q     <= oe_n_d;
      data_oe_q  <= data_oe_d;
      ram_addr_q <= ram_addr_d;
      ram_wdat_q <= ram_wdat_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign pi_done_out  = done_q;
  assign pi_rd_data   = rd_data_q;
  assign ram_addr     = ram_addr_q;
  assign ram_data_out = ram_wdat_q;
  assign ram_data_oe  = data_oe_q;
  assign ram_we_n     = we_n_q;
  assign ram_oe_n     = oe_n_q;

endmodule

// File: doc/pi_access.md
PI_ACCESS -- requirements
Module: pi_access

Interface
REQ-001 Parameter ACCESS_CYCLES, default 3, number of clk cycles a RAM access occupies (legal range 2..15).
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 reset  input  1  reset is asynchronous and active-high.
REQ-004 pi_pending_in  input  1  request level from the SPI command stage (spi_sclk domain, asynchronous to clk).
REQ-005 pi_addr  input  17  access address, stable while pi_pending_in high.
REQ-006 pi_data_in  input  8  write data, stable while pi_pending_in high.
REQ-007 pi_rw_b  input  1  1=read, 0=write.
REQ-008 pi_slot  input  1  one-clk strobe from timing generator granting the Pi a bus slot.
REQ-009 pi_done_out  output  1  completion level returned to SPI stage's pi_done_in.
REQ-010 pi_rd_data  output  8  data read from RAM, valid while pi_done_out high after a read.
REQ-011 ram_addr  output  17  RAM address.
REQ-012 ram_data_out  output  8  RAM write data.
REQ-013 ram_data_oe  output  1  enables ram_data_out onto shared data bus.
REQ-014 ram_data_in  input  8  RAM read data.
REQ-015 ram_we_n, ram_oe_n  output  1 each  active-low RAM strobes.

Function
REQ-016 pi_pending_in SHALL pass through a two-flop synchronizer before use; "pend_s" denotes its output.
REQ-017 States SHALL be IDLE, WAIT_SLOT, ACCESS, DONE.
REQ-018 IDLE: on pend_s=1, capture pi_addr/pi_data_in/pi_rw_b into internal registers and go to WAIT_SLOT.
REQ-019 WAIT_SLOT: stay until pi_slot=1; on that edge go to ACCESS with cycle counter=0; ignore pi_slot in every other state.
REQ-020 ACCESS: ram_addr=captured address for all ACCESS_CYCLES cycles; counter increments each cycle; exit after cycle ACCESS_CYCLES-1.
REQ-021 Write: ram_data_oe=1 and ram_data_out=captured data for all ACCESS cycles; ram_we_n=0 in cycles 0..ACCESS_CYCLES-2, 1 in final cycle (data hold).
REQ-022 Read: ram_oe_n=0 for all ACCESS cycles; ram_data_in sampled into pi_rd_data on the edge ending the final cycle.
REQ-023 Outside ACCESS: ram_we_n=1, ram_oe_n=1, ram_data_oe=0; ram_addr/ram_data_out hold last value.
REQ-024 After ACCESS, go to DONE if pend_s=1, else IDLE (abort: access completes, pi_done_out never asserts).
REQ-025 DONE: pi_done_out=1; stay until pend_s=0, then IDLE with pi_done_out=0 on the same edge.
REQ-026 Latency: pi_done_out rises exactly ACCESS_CYCLES+1 edges after the edge sampling pi_slot=1.
REQ-027 pend_s falling in WAIT_SLOT SHALL return to IDLE without any RAM strobe.
REQ-028 An ACCESS in progress SHALL never be truncated except by reset.
REQ-029 pi_rd_data SHALL hold its value until the next read completes; writes do not alter it.
REQ-030 pi_done_out SHALL be a registered output (glitch-free for cross-domain sampling).

Reset
REQ-031 reset=1 SHALL immediately force IDLE, counter=0, pi_done_out=0, ram_we_n=1, ram_oe_n=1, ram_data_oe=0, ram_addr=0, ram_data_out=0, pi_rd_data=0, synchronizer flops=0.
REQ-032 Reset mid-ACCESS SHALL release strobes asynchronously; no access resumes after reset release.

Structure
REQ-033 Shared package SHALL hold the state enum (pi_access_state_t), address width 17, data width 8.
REQ-034 Synchronizer SHALL be a separate sub-module named sync2 (width parameter, async active-high reset), reused for other crossings.
REQ-035 Counter width SHALL be $clog2(ACCESS_CYCLES+1).

Verification
REQ-036 Write: addr=17'h08000, data=8'hA5, rw_b=0, pend=1, pi_slot pulse -> ram_we_n low 2 cycles, high 1, data bus A5, pi_done_out high at slot+4 edges.
REQ-037 Read: addr=17'h1FFFF, RAM model returns 8'h3C -> ram_oe_n low 3 cycles, pi_rd_data=3C, pi_done_out high; drop pend -> pi_done_out low within 3 clks.
REQ-038 Slot ignored: pi_slot pulsing every 4 clks during ACCESS/DONE -> exactly one access per request.
REQ-039 Abort: pend dropped during ACCESS cycle 1 -> full 3-cycle access, pi_done_out stays 0, back to IDLE.
REQ-040 Reset mid-write (ACCESS cycle 1) -> ram_we_n=1 and ram_data_oe=0 same timestep, all outputs at reset values.
REQ-041 Back-to-back: write 8'h11 then read same address -> pi_rd_data=11, each pi_done_out cleared before the next request.
